// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU-writable TX FIFO feeding a frame serialiser
// with configurable data bits, parity and stop bits, plus a pollable status register.
module uart_tx_mmio #(
    parameter int                         ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0]   DATA_ADDR     = 16'hFFFF,
    parameter logic [ADDRESS_WIDTH-1:0]   STAT_ADDR     = 16'hFFFE,
    parameter int                         FIFO_AW       = 4,
    parameter int                         BAUD_DIV      = 104,
    parameter int                         DATA_BITS     = 8,
    parameter int                         PARITY        = 0,
    parameter int                         STOP_BITS     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [7:0]               data_in,
    input  logic                     wren,
    output logic [7:0]               data_out,
    output logic                     ready,
    output logic                     busy,
    output logic                     txd
);

    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C   = DEPTH[FIFO_AW:0];
    localparam logic [11:0]      BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, state_next;
    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
    logic [FIFO_AW:0]       count;
    logic                   overflow;
    logic [11:0]            baud_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift, shift_next, head;
    logic                   par_bit, par_next;
    logic                   txd_q, txd_next;
    logic                   full, empty, push_req, push, pop, stat_clr;
    logic                   baud_end, adv, bit_clr, bit_inc;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        if (PARITY == 2)
            return ^d;
        return ~^d;
    endfunction

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign push_req = wren && (address == DATA_ADDR);
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign stat_clr = wren && (address == STAT_ADDR) && data_in[3];
    assign baud_end = (baud_cnt == BAUD_LAST);

    assign ready    = !full;
    assign busy     = (state != IDLE) || !empty;
    assign txd      = txd_q;
    assign data_out = (address == STAT_ADDR) ? {4'b0000, overflow, busy, full, empty} : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift_next = shift;
        par_next   = par_bit;
        adv        = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    par_next   = parity_of(head);
                    state_next = START;
                    adv        = 1'b1;
                    bit_clr    = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next = DATA;
                    adv        = 1'b1;
                    bit_clr    = 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    adv = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_next = (PARITY != 0) ? PAR : STOP;
                        bit_clr    = 1'b1;
                    end else begin
                        shift_next = shift >> 1;
                        bit_inc    = 1'b1;
                    end
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_next = STOP;
                    adv        = 1'b1;
                    bit_clr    = 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    adv = 1'b1;
                    if (bit_cnt == STOP_LAST) begin
                        bit_clr = 1'b1;
                        // Chain straight into the next start bit when data is waiting.
                        if (!empty) begin
                            pop        = 1'b1;
                            shift_next = head;
                            par_next   = parity_of(head);
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            PAR:     txd_next = par_next;
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd_q    <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Setting wins over a same-cycle clear so no drop goes unreported.
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (stat_clr)
                overflow <= 1'b0;
            if (adv || state_next == IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (bit_clr)
                bit_cnt <= '0;
            else if (bit_inc)
                bit_cnt <= bit_cnt + 1'b1;
            txd_q <= txd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in[DATA_BITS-1:0];
        shift   <= shift_next;
        par_bit <= par_next;
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: an 8N1 instance with a 4-deep FIFO plus two 7-bit,
// 2-stop-bit instances with even and odd parity, all at 4 clocks per bit.
module tb_uart_tx_mmio;

    localparam logic [15:0] DATA_A = 16'hFFFF;
    localparam logic [15:0] STAT_A = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        wren0, wren1, wren2;
    logic [7:0]  data_out0, data_out1, data_out2;
    logic        ready0, ready1, ready2;
    logic        busy0, busy1, busy2;
    logic        txd0, txd1, txd2;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int wr_cyc = 0;
    int rst_cnt = 0;
    bit mon_busy = 1'b0;

    typedef struct { logic [7:0] data; bit b2b; } exp_t;
    typedef struct { logic [6:0] data; logic par; } pexp_t;
    exp_t  q0[$];
    pexp_t q1[$];
    pexp_t q2[$];

    uart_tx_mmio #(.FIFO_AW(2), .BAUD_DIV(4)) u0 (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wren(wren0),
        .data_out(data_out0), .ready(ready0), .busy(busy0), .txd(txd0));

    uart_tx_mmio #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wren(wren1),
        .data_out(data_out1), .ready(ready1), .busy(busy1), .txd(txd1));

    uart_tx_mmio #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wren(wren2),
        .data_out(data_out2), .ready(ready2), .busy(busy2), .txd(txd2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst) rst_cnt = rst_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [2:0] sel);
        address = a;
        data_in = d;
        {wren2, wren1, wren0} = sel;
        @(posedge clk);
        #1;
        {wren2, wren1, wren0} = 3'b000;
        address = 16'h0000;
        wr_cyc  = cyc;
    endtask

    task automatic wait_idle(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (!busy0 && !mon_busy && q0.size() == 0)
                done = 1'b1;
        end
        chk("drain", done, 1'b1);
    endtask

    // Serial receiver for the 8N1 instance: samples each 4-cycle slot at its second clock.
    initial begin
        int         s;
        int         prev_start;
        int         rc;
        logic [9:0] bits;
        exp_t       e;
        prev_start = -1000;
        forever begin
            @(negedge clk);
            if (rst || txd0)
                continue;
            mon_busy = 1'b1;
            s  = cyc;
            rc = rst_cnt;
            @(negedge clk);
            bits[0] = txd0;
            for (int k = 1; k < 10; k++) begin
                repeat (4) @(negedge clk);
                bits[k] = txd0;
            end
            repeat (2) @(negedge clk);
            if (rc == rst_cnt) begin
                if (q0.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("start_bit", bits[0], 1'b0);
                    chk("data_byte", bits[8:1], e.data);
                    chk("stop_bit", bits[9], 1'b1);
                    if (e.b2b)
                        chk("b2b_gap", s - prev_start, 40);
                end
            end
            prev_start = s;
            mon_busy = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         w;
        int         w1;
        logic [10:0] b1, b2;
        pexp_t      p;

        rst = 1'b1;
        address = 16'h0000;
        data_in = 8'h00;
        {wren2, wren1, wren0} = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_txd", txd0, 1'b1);
        chk("rst_ready", ready0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_dout_other", data_out0, 8'h00);
        chk("rst_txd_par", {txd1, txd2}, 2'b11);
        address = STAT_A;
        #1 chk("rst_status", data_out0, 8'h01);
        address = 16'h0000;

        // Single 8N1 frame: latency and busy fall
        @(posedge clk);
        #1;
        q0.push_back('{8'h55, 1'b0});
        wr(DATA_A, 8'h55, 3'b001);
        @(negedge clk);
        chk("lat_txd_high", txd0, 1'b1);
        @(negedge clk);
        chk("lat_txd_low", txd0, 1'b0);
        repeat (39) @(negedge clk);
        chk("busy_last_cycle", busy0, 1'b1);
        @(negedge clk);
        chk("busy_fall", busy0, 1'b0);
        wait_idle(100);

        // Back-to-back frames
        q0.push_back('{8'hA5, 1'b0});
        wr(DATA_A, 8'hA5, 3'b001);
        q0.push_back('{8'h3C, 1'b1});
        wr(DATA_A, 8'h3C, 3'b001);
        wait_idle(200);

        // Fill, overflow, clear, then a write on the exact pop edge while full
        w1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                q0.push_back('{8'(8'h10 + i), (i != 0)});
            wr(DATA_A, 8'(8'h10 + i), 3'b001);
            if (i == 0)
                w1 = wr_cyc;
            if (i == 3)
                chk("ready_three_held", ready0, 1'b1);
            if (i == 4)
                chk("ready_full", ready0, 1'b0);
        end
        address = STAT_A;
        #1 chk("status_overflow", data_out0, 8'h0E);
        wr(STAT_A, 8'h08, 3'b001);
        address = STAT_A;
        #1 chk("status_cleared", data_out0, 8'h06);
        address = 16'h0000;
        while (cyc < w1 + 40) begin
            @(posedge clk);
            #1;
        end
        q0.push_back('{8'h77, 1'b1});
        wr(DATA_A, 8'h77, 3'b001);
        address = STAT_A;
        #1 chk("pushpop_full_status", data_out0, 8'h06);
        chk("pushpop_ready", ready0, 1'b0);
        address = 16'h0000;
        wait_idle(600);

        // Parity frames: 7 data bits, even (u1) and odd (u2), two stop bits
        q1.push_back('{7'h41, 1'b0});
        q2.push_back('{7'h41, 1'b1});
        wr(DATA_A, 8'h41, 3'b110);
        w = wr_cyc;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            repeat ((k == 0) ? 1 : 4) @(negedge clk);
            b1[k] = txd1;
            b2[k] = txd2;
        end
        repeat (2) @(negedge clk);
        chk("par_busy_last", {busy1, busy2}, 2'b11);
        @(negedge clk);
        chk("par_busy_fall", {busy1, busy2}, 2'b00);
        chk("par_frame_end_cycle", cyc - w, 45);
        p = q1.pop_front();
        chk("even_start", b1[0], 1'b0);
        chk("even_data", b1[7:1], p.data);
        chk("even_par", b1[8], p.par);
        chk("even_stop", b1[10:9], 2'b11);
        p = q2.pop_front();
        chk("odd_start", b2[0], 1'b0);
        chk("odd_data", b2[7:1], p.data);
        chk("odd_par", b2[8], p.par);
        chk("odd_stop", b2[10:9], 2'b11);

        // Reset in the middle of the data bits
        q0.push_back('{8'hF0, 1'b0});
        wr(DATA_A, 8'hF0, 3'b001);
        repeat (12) @(posedge clk);
        #1 chk("pre_rst_txd", txd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_txd", txd0, 1'b1);
        chk("rst_mid_busy", busy0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        repeat (50) @(posedge clk);
        #1;
        address = STAT_A;
        #1 chk("post_rst_status", data_out0, 8'h01);
        address = 16'h0000;
        q0.push_back('{8'h3C, 1'b0});
        wr(DATA_A, 8'h3C, 3'b001);
        wait_idle(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
